// File: rtl/fpu_pipe_chain.sv
// Elastic register chain for recoded FP words between FPU stages.
// Each stage has its own valid bit, and empty stages collapse bubbles.
module fpu_pipe_chain #(
  parameter int SIZE  = 32,
  parameter int DEPTH = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         in_valid,
  input  logic [SIZE:0]                in_data,
  output logic                         in_ready,
  output logic                         out_valid,
  output logic [SIZE:0]                out_data,
  input  logic                         out_ready,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

  localparam int OCC_W = $clog2(DEPTH+1);

  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] v_next;
  logic [DEPTH-1:0] load;
  logic [DEPTH:0]   r;
  logic [SIZE:0]    d [DEPTH];

  // A stage is ready when it is empty or any stage between it and the output is
  // empty, or when the sink takes the output word. Each ready is built directly
  // from the valid bits, so no ready term depends on another ready term.
  // NOTE: combinational blocks use blocking '=' with a default first, so no latch is inferred.
  always_comb begin
    logic acc;
    r        = '0;
    r[DEPTH] = out_ready;
    for (int i = 0; i < DEPTH; i++) begin
      acc = out_ready;
      for (int j = i; j < DEPTH; j++) begin
        acc = acc | ~v[j];
      end
      r[i] = acc;
    end
  end

  assign in_ready = r[0] & ~flush;

  // A stage's load is gated during flush, so its data word holds its value.
  always_comb begin
    load    = '0;
    load[0] = in_valid & in_ready;
    for (int i = 1; i < DEPTH; i++) begin
      load[i] = v[i-1] & r[i] & ~flush;
    end
  end

  always_comb begin
    v_next = '0;
    for (int i = 0; i < DEPTH; i++) begin
      v_next[i] = load[i] | (v[i] & ~r[i+1]);
    end
  end

  // NOTE: sequential state uses non-blocking '<=' so all stages shift on the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v <= '0;
    end else if (flush) begin
      v <= '0;
    end else begin
      v <= v_next;
    end
  end

  // NOTE: the data array is reset as well, because out_data must read zero while in reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        d[i] <= '0;
      end
    end else begin
      if (load[0]) begin
        d[0] <= in_data;
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (load[i]) begin
          d[i] <= d[i-1];
        end
      end
    end
  end

  assign out_valid = v[DEPTH-1];
  assign out_data  = d[DEPTH-1];

  always_comb begin
    logic [OCC_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      cnt = cnt + OCC_W'(v[i]);
    end
    occupancy = cnt;
  end

endmodule

// File: tb/tb_fpu_pipe_chain.sv
// Self-checking bench for fpu_pipe_chain: directed table at DEPTH=3 plus a
// randomized queue-model scoreboard at DEPTH=1 and DEPTH=5.
module tb_fpu_pipe_chain;

  typedef logic [32:0] word_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // DEPTH=3 instance
  logic        iv3 = 0, or3 = 0, fl3 = 0;
  word_t       id3 = '0;
  logic        ir3, ov3;
  word_t       od3;
  logic [1:0]  occ3;

  // DEPTH=1 instance
  logic        iv1 = 0, or1 = 0, fl1 = 0;
  word_t       id1 = '0;
  logic        ir1, ov1;
  word_t       od1;
  logic [0:0]  occ1;

  // DEPTH=5 instance
  logic        iv5 = 0, or5 = 0, fl5 = 0;
  word_t       id5 = '0;
  logic        ir5, ov5;
  word_t       od5;
  logic [2:0]  occ5;

  fpu_pipe_chain #(.SIZE(32), .DEPTH(3)) u3 (
    .clk(clk), .rst(rst), .flush(fl3), .in_valid(iv3), .in_data(id3),
    .in_ready(ir3), .out_valid(ov3), .out_data(od3), .out_ready(or3), .occupancy(occ3));

  fpu_pipe_chain #(.SIZE(32), .DEPTH(1)) u1 (
    .clk(clk), .rst(rst), .flush(fl1), .in_valid(iv1), .in_data(id1),
    .in_ready(ir1), .out_valid(ov1), .out_data(od1), .out_ready(or1), .occupancy(occ1));

  fpu_pipe_chain #(.SIZE(32), .DEPTH(5)) u5 (
    .clk(clk), .rst(rst), .flush(fl5), .in_valid(iv5), .in_data(id5),
    .in_ready(ir5), .out_valid(ov5), .out_data(od5), .out_ready(or5), .occupancy(occ5));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Directed vectors: inputs for one cycle and the outputs expected before its edge.
  typedef struct {
    logic  iv;
    word_t data;
    logic  ordy;
    logic  eir;
    logic  eov;
    word_t edata;
    int    eocc;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic iv, input word_t data, input logic ordy,
                     input logic eir, input logic eov, input word_t edata, input int eocc);
    vec_t e;
    e.iv = iv; e.data = data; e.ordy = ordy;
    e.eir = eir; e.eov = eov; e.edata = edata; e.eocc = eocc;
    tbl.push_back(e);
  endtask

  task automatic drive3(input logic iv, input word_t data, input logic ordy, input logic fl);
    @(negedge clk);
    iv3 = iv; id3 = data; or3 = ordy; fl3 = fl;
    #1;
  endtask

  // Reference model for the random runs: an ordered queue of words in flight.
  // In-order, lossless delivery means the output word is always the oldest accepted.
  word_t q[2][$];
  int    accepted[2];
  int    delivered[2];
  int    flushed[2];

  task automatic model_step(input int k, input int depth, input logic iv, input word_t idata,
                            input logic ordy, input logic fl, input logic ir, input logic ov,
                            input word_t od, input int occ);
    int sz;
    sz = q[k].size();
    check($sformatf("d%0d occupancy", depth), 64'(occ), 64'(sz));
    check($sformatf("d%0d in_ready", depth), 64'(ir), 64'(!fl && (sz < depth || ordy)));
    if (sz == 0) check($sformatf("d%0d out_valid empty", depth), 64'(ov), 64'(0));
    if (ov && sz > 0) check($sformatf("d%0d out_data order", depth), 64'(od), 64'(q[k][0]));
    if (ov && ordy && sz > 0) begin
      void'(q[k].pop_front());
      delivered[k]++;
    end
    if (iv && ir) begin
      q[k].push_back(idata);
      accepted[k]++;
    end
    if (fl) begin
      flushed[k] += q[k].size();
      q[k].delete();
    end
  endtask

  localparam word_t A0 = 33'h0_3F800000;
  localparam word_t A1 = 33'h0_40000000;
  localparam word_t A2 = 33'h0_40400000;
  localparam word_t W1 = 33'h1_00000011;
  localparam word_t W2 = 33'h0_22220022;
  localparam word_t W3 = 33'h1_33330033;
  localparam word_t W4 = 33'h0_44440044;
  localparam word_t BA = 33'h1_C0A00000;
  localparam word_t BB = 33'h0_41200000;

  initial begin
    // ---------------- reset state ----------------
    rst = 1'b0;
    #12;
    check("reset out_valid", 64'(ov3), 64'(0));
    check("reset out_data", 64'(od3), 64'(0));
    check("reset occupancy", 64'(occ3), 64'(0));
    check("reset in_ready", 64'(ir3), 64'(1));
    @(negedge clk);
    rst = 1'b1;

    // ---------------- table: streaming, back-pressure, bubble collapse ----------------
    // streaming with out_ready=1: first word appears 3 cycles after its acceptance
    add(1, A0, 1, 1, 0, '0, 0);
    add(1, A1, 1, 1, 0, '0, 1);
    add(1, A2, 1, 1, 0, '0, 2);
    add(0, '0, 1, 1, 1, A0, 3);
    add(0, '0, 1, 1, 1, A1, 2);
    add(0, '0, 1, 1, 1, A2, 1);
    add(0, '0, 1, 1, 0, '0, 0);
    // back-pressure: three accepted, fourth refused until out_ready rises
    add(1, W1, 0, 1, 0, '0, 0);
    add(1, W2, 0, 1, 0, '0, 1);
    add(1, W3, 0, 1, 0, '0, 2);
    add(1, W4, 0, 0, 1, W1, 3);
    add(1, W4, 1, 1, 1, W1, 3);
    add(0, '0, 1, 1, 1, W2, 3);
    add(0, '0, 1, 1, 1, W3, 2);
    add(0, '0, 1, 1, 1, W4, 1);
    add(0, '0, 1, 1, 0, '0, 0);
    // bubble collapse: A drifts to the output, B closes up behind it while stalled
    add(1, BA, 0, 1, 0, '0, 0);
    add(0, '0, 0, 1, 0, '0, 1);
    add(0, '0, 0, 1, 0, '0, 1);
    add(1, BB, 0, 1, 1, BA, 1);
    add(0, '0, 0, 1, 1, BA, 2);
    add(0, '0, 0, 1, 1, BA, 2);
    add(0, '0, 1, 1, 1, BA, 2);
    add(0, '0, 1, 1, 1, BB, 1);
    add(0, '0, 1, 1, 0, '0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      drive3(tbl[i].iv, tbl[i].data, tbl[i].ordy, 1'b0);
      check($sformatf("vec%0d in_ready", i), 64'(ir3), 64'(tbl[i].eir));
      check($sformatf("vec%0d out_valid", i), 64'(ov3), 64'(tbl[i].eov));
      check($sformatf("vec%0d occupancy", i), 64'(occ3), 64'(tbl[i].eocc));
      if (tbl[i].eov) check($sformatf("vec%0d out_data", i), 64'(od3), 64'(tbl[i].edata));
    end

    // ---------------- flush with three words in flight ----------------
    drive3(1, W1, 0, 0);
    drive3(1, W2, 0, 0);
    drive3(1, W3, 0, 0);
    drive3(1, W4, 0, 1);
    check("flush in_ready low", 64'(ir3), 64'(0));
    check("flush out_valid held", 64'(ov3), 64'(1));
    check("flush occupancy before edge", 64'(occ3), 64'(3));
    drive3(0, '0, 1, 0);
    check("post-flush occupancy", 64'(occ3), 64'(0));
    check("post-flush out_valid", 64'(ov3), 64'(0));
    for (int i = 0; i < 4; i++) begin
      drive3(0, '0, 1, 0);
      check($sformatf("no flushed word %0d", i), 64'(ov3), 64'(0));
    end

    // ---------------- flush together with a completing output transfer ----------------
    drive3(1, A0, 0, 0);
    drive3(1, A1, 0, 0);
    drive3(0, '0, 0, 0);
    drive3(0, '0, 1, 1);
    check("flush+xfer out_valid", 64'(ov3), 64'(1));
    check("flush+xfer out_data", 64'(od3), 64'(A0));
    drive3(1, A2, 1, 0);
    check("flush+xfer empty", 64'(occ3), 64'(0));
    check("flush+xfer accepts", 64'(ir3), 64'(1));
    drive3(0, '0, 1, 0);
    drive3(0, '0, 1, 0);
    drive3(0, '0, 1, 0);
    check("post-flush new word valid", 64'(ov3), 64'(1));
    check("post-flush new word data", 64'(od3), 64'(A2));

    // ---------------- asynchronous reset mid-stream ----------------
    drive3(0, '0, 1, 0);
    drive3(1, W1, 0, 0);
    drive3(1, W2, 0, 0);
    drive3(0, '0, 0, 0);
    check("pre-reset occupancy", 64'(occ3), 64'(2));
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("async reset out_valid", 64'(ov3), 64'(0));
    check("async reset out_data", 64'(od3), 64'(0));
    check("async reset occupancy", 64'(occ3), 64'(0));
    @(negedge clk);
    rst = 1'b1;
    iv3 = 1; id3 = W3; or3 = 1; fl3 = 0;
    #1;
    check("reset release in_ready", 64'(ir3), 64'(1));
    drive3(0, '0, 1, 0);
    drive3(0, '0, 1, 0);
    drive3(0, '0, 1, 0);
    check("reset release word valid", 64'(ov3), 64'(1));
    check("reset release word data", 64'(od3), 64'(W3));
    drive3(0, '0, 1, 0);

    // ---------------- random scoreboard, DEPTH=1 and DEPTH=5 ----------------
    for (int k = 0; k < 2; k++) begin
      accepted[k] = 0; delivered[k] = 0; flushed[k] = 0;
    end
    for (int c = 0; c < 10000; c++) begin
      logic stall;
      @(negedge clk);
      // Phases of heavy back-pressure let the chains fill completely.
      stall = ((c / 200) % 3) == 1;
      iv1 = ($urandom_range(0, 3) != 0);
      id1 = {1'($urandom_range(0, 1)), 32'($urandom)};
      or1 = stall ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
      fl1 = ($urandom_range(0, 99) == 0);
      iv5 = ($urandom_range(0, 3) != 0);
      id5 = {1'($urandom_range(0, 1)), 32'($urandom)};
      or5 = stall ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
      fl5 = ($urandom_range(0, 99) == 0);
      #1;
      model_step(0, 1, iv1, id1, or1, fl1, ir1, ov1, od1, int'(occ1));
      model_step(1, 5, iv5, id5, or5, fl5, ir5, ov5, od5, int'(occ5));
    end
    // drain both chains and confirm nothing is left behind
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      iv1 = 0; or1 = 1; fl1 = 0;
      iv5 = 0; or5 = 1; fl5 = 0;
      #1;
      model_step(0, 1, iv1, id1, or1, fl1, ir1, ov1, od1, int'(occ1));
      model_step(1, 5, iv5, id5, or5, fl5, ir5, ov5, od5, int'(occ5));
    end
    check("d1 drained occupancy", 64'(occ1), 64'(0));
    check("d5 drained occupancy", 64'(occ5), 64'(0));
    check("d1 conservation", 64'(accepted[0]), 64'(delivered[0] + flushed[0]));
    check("d5 conservation", 64'(accepted[1]), 64'(delivered[1] + flushed[1]));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
